uart_tx_drain: RTL



---
 rtl/uart_tx_drain_if.sv | 19 +
 rtl/uart_tx_drain.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_tx_drain_if.sv
// FIFO-side handshake for the UART drain: empty flag and registered data from the
// FIFO, pop request back to it.
interface uart_tx_drain_if;
    logic       empty;
    logic [7:0] data_in;
    logic       pop;

    modport master (
        input  empty,
        input  data_in,
        output pop
    );

    modport slave (
        output empty,
        output data_in,
        input  pop
    );
endinterface

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that pops bytes from an upstream FIFO whenever it is non-empty.
// All outputs are registered and decoded from the next state so they align with it.
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_tx_drain_if.master        fifo,
    output logic                   tx,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_baud;
    logic [15:0] w_baud_next;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        w_baud_end;
    logic        w_timed;
    logic        r_tx;
    logic        r_pop;
    logic        r_busy;
    logic        w_tx_next;
    logic        w_pop_next;
    logic        w_busy_next;

    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_timed    = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

    // State register plus the datapath registers that move with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
            r_pop   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_pop   <= w_pop_next;
            r_busy  <= w_busy_next;
        end
    end

    // Next-state and counter logic; empty is only looked at while idle.
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        case (r_state)
            S_IDLE: begin
                if (!fifo.empty) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_state_next = S_START;
                w_shift_next = fifo.data_in;
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_bit_next   = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_state_next != S_DATA) begin
            w_bit_next = 3'd0;
        end

        if ((w_state_next != r_state) || !w_timed || w_baud_end) begin
            w_baud_next = 16'd0;
        end else begin
            w_baud_next = r_baud + 16'd1;
        end
    end

    // Output decode from the upcoming state so the registered outputs track it exactly.
    always_comb begin
        w_pop_next  = (w_state_next == S_FETCH);
        w_busy_next = (w_state_next != S_IDLE);
        w_tx_next   = 1'b1;
        if (w_state_next == S_START) begin
            w_tx_next = 1'b0;
        end else if (w_state_next == S_DATA) begin
            w_tx_next = w_shift_next[0];
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign fifo.pop = r_pop;

endmodule
